// File: rtl/region_attr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : region_attr_pkg
// Description : Shared types for the runtime-programmable region attribute table.
// Revision    : 1.0 - initial release
// ============================================================================
package region_attr_pkg;

    localparam int c_addr_width_max = 64;

    typedef struct packed {
        logic nonidem;
        logic cached;
        logic exec;
    } attr_t;

    // Fields are stored at the widest supported address width; the top
    // module only ever uses the low ADDR_WIDTH bits.
    typedef struct packed {
        logic [c_addr_width_max-1:0] base;
        logic [c_addr_width_max-1:0] length;
        attr_t                       attr;
        logic                        lock;
    } entry_t;

    typedef enum logic [1:0] {
        FIELD_BASE   = 2'd0,
        FIELD_LENGTH = 2'd1,
        FIELD_ATTR   = 2'd2,
        FIELD_RSVD   = 2'd3
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_COPY  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/region_attr_match.sv
`default_nettype none
// ============================================================================
// Module      : region_attr_match
// Description : Combinational lowest-index-wins region match for one port.
// Revision    : 1.0 - initial release
// ============================================================================
module region_attr_match
    import region_attr_pkg::*;
#(
    parameter int NR_RULES   = 8,
    parameter int ADDR_WIDTH = 64
) (
    input  entry_t [NR_RULES-1:0] i_bank,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_hit,
    output attr_t                 o_attr
);

    logic [NR_RULES-1:0] w_match;
    logic [NR_RULES-1:0] w_lock_unused;
    logic                w_unused;

    // Modulo subtraction lets a region wrap past the top of the address space.
    for (genvar i = 0; i < NR_RULES; i++) begin : g_entry
        logic [ADDR_WIDTH-1:0] w_offset;
        logic [ADDR_WIDTH-1:0] w_length;
        assign w_length         = i_bank[i].length[ADDR_WIDTH-1:0];
        assign w_offset         = i_addr - i_bank[i].base[ADDR_WIDTH-1:0];
        assign w_match[i]       = (w_length != '0) && (w_offset < w_length);
        assign w_lock_unused[i] = i_bank[i].lock;
    end

    assign w_unused = ^w_lock_unused;

    always_comb begin
        o_hit  = 1'b0;
        o_attr = '0;
        for (int i = NR_RULES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit  = 1'b1;
                o_attr = i_bank[i].attr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/region_attr_table.sv
`default_nettype none
// ============================================================================
// Module      : region_attr_table
// Description : Shadow/active region attribute table with atomic commit and
//               NR_PORTS single-cycle lookup channels.
// Revision    : 1.0 - initial release
// ============================================================================
module region_attr_table
    import region_attr_pkg::*;
#(
    parameter int                          NR_RULES   = 8,
    parameter int                          NR_PORTS   = 2,
    parameter int                          ADDR_WIDTH = 64,
    parameter logic [15:0][ADDR_WIDTH-1:0] RST_BASE   = '0,
    parameter logic [15:0][ADDR_WIDTH-1:0] RST_LENGTH = '0,
    parameter logic [15:0][2:0]            RST_ATTR   = '0,
    parameter logic [15:0]                 RST_LOCK   = '0,
    localparam int                         IDX_W      = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_req_i,
    output logic                                cfg_gnt_o,
    input  logic                                cfg_we_i,
    input  logic [IDX_W-1:0]                    cfg_idx_i,
    input  logic [1:0]                          cfg_field_i,
    input  logic [ADDR_WIDTH-1:0]               cfg_wdata_i,
    output logic                                cfg_rvalid_o,
    output logic [ADDR_WIDTH-1:0]               cfg_rdata_o,
    output logic                                cfg_err_o,
    input  logic                                commit_i,
    output logic                                commit_busy_o,
    input  logic [NR_PORTS-1:0]                 lk_valid_i,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] lk_addr_i,
    output logic [NR_PORTS-1:0]                 lk_ready_o,
    output logic [NR_PORTS-1:0]                 lk_rvalid_o,
    output logic [NR_PORTS-1:0]                 lk_hit_o,
    output logic [NR_PORTS-1:0][2:0]            lk_attr_o
);

    localparam logic [IDX_W:0] c_nr_rules = (IDX_W + 1)'(NR_RULES);

    entry_t [NR_RULES-1:0]   r_shadow;
    entry_t [NR_RULES-1:0]   r_active;
    entry_t [NR_RULES-1:0]   w_rst_bank;
    state_e                  r_state;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_cfg_rvalid;
    logic [ADDR_WIDTH-1:0]   r_cfg_rdata;
    logic                    r_cfg_err;
    logic [NR_PORTS-1:0]     r_lk_rvalid;
    logic [NR_PORTS-1:0]     r_lk_hit;
    logic [NR_PORTS-1:0][2:0] r_lk_attr;

    logic                    w_idx_ok;
    logic                    w_wr_err;
    logic [c_addr_width_max-1:0] w_wdata_ext;
    logic [ADDR_WIDTH-1:0]   w_rdata;
    logic [NR_PORTS-1:0]     w_lk_acc;
    logic [NR_PORTS-1:0]     w_hit;
    attr_t [NR_PORTS-1:0]    w_attr;

    always_comb begin
        w_rst_bank = '0;
        for (int i = 0; i < NR_RULES; i++) begin
            w_rst_bank[i].base[ADDR_WIDTH-1:0]   = RST_BASE[i];
            w_rst_bank[i].length[ADDR_WIDTH-1:0] = RST_LENGTH[i];
            w_rst_bank[i].attr                   = attr_t'(RST_ATTR[i]);
            w_rst_bank[i].lock                   = RST_LOCK[i];
        end
    end

    assign w_idx_ok  = {1'b0, cfg_idx_i} < c_nr_rules;
    assign w_wr_err  = (field_e'(cfg_field_i) == FIELD_RSVD) || !w_idx_ok
                     || r_shadow[cfg_idx_i].lock;
    assign cfg_gnt_o = cfg_req_i && !r_busy;

    always_comb begin
        w_wdata_ext                   = '0;
        w_wdata_ext[ADDR_WIDTH-1:0]   = cfg_wdata_i;
    end

    always_comb begin
        w_rdata = '0;
        if (w_idx_ok) begin
            case (field_e'(cfg_field_i))
                FIELD_BASE:   w_rdata = r_shadow[cfg_idx_i].base[ADDR_WIDTH-1:0];
                FIELD_LENGTH: w_rdata = r_shadow[cfg_idx_i].length[ADDR_WIDTH-1:0];
                FIELD_ATTR:   w_rdata[3:0] = {r_shadow[cfg_idx_i].lock, r_shadow[cfg_idx_i].attr};
                default:      w_rdata = '0;
            endcase
        end
    end

    assign w_lk_acc = lk_valid_i & lk_ready_o;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        region_attr_match #(
            .NR_RULES   (NR_RULES),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_match (
            .i_bank (r_active),
            .i_addr (lk_addr_i[p]),
            .o_hit  (w_hit[p]),
            .o_attr (w_attr[p])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_ready      <= 1'b1;
            r_shadow     <= w_rst_bank;
            r_active     <= w_rst_bank;
            r_cfg_rvalid <= 1'b0;
            r_cfg_rdata  <= '0;
            r_cfg_err    <= 1'b0;
            r_lk_rvalid  <= '0;
            r_lk_hit     <= '0;
            r_lk_attr    <= '0;
        end else begin
            r_cfg_rvalid <= cfg_gnt_o && !cfg_we_i;
            r_cfg_rdata  <= (cfg_gnt_o && !cfg_we_i) ? w_rdata : '0;
            r_cfg_err    <= cfg_gnt_o && (cfg_we_i ? w_wr_err : !w_idx_ok);

            if (cfg_gnt_o && cfg_we_i && !w_wr_err) begin
                case (field_e'(cfg_field_i))
                    FIELD_BASE:   r_shadow[cfg_idx_i].base   <= w_wdata_ext;
                    FIELD_LENGTH: r_shadow[cfg_idx_i].length <= w_wdata_ext;
                    default: begin
                        r_shadow[cfg_idx_i].attr <= attr_t'(cfg_wdata_i[2:0]);
                        r_shadow[cfg_idx_i].lock <= cfg_wdata_i[3];
                    end
                endcase
            end

            // DRAIN lets lookups accepted on the commit cycle finish on the old bank.
            case (r_state)
                ST_IDLE: begin
                    if (commit_i) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_DRAIN: r_state <= ST_COPY;
                ST_COPY: begin
                    r_active <= r_shadow;
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_ready  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase

            for (int p = 0; p < NR_PORTS; p++) begin
                r_lk_rvalid[p] <= w_lk_acc[p];
                r_lk_hit[p]    <= w_lk_acc[p] && w_hit[p];
                r_lk_attr[p]   <= w_lk_acc[p] ? w_attr[p] : 3'b000;
            end
        end
    end

    assign commit_busy_o = r_busy;
    assign lk_ready_o    = {NR_PORTS{r_ready}};
    assign cfg_rvalid_o  = r_cfg_rvalid;
    assign cfg_rdata_o   = r_cfg_rdata;
    assign cfg_err_o     = r_cfg_err;
    assign lk_rvalid_o   = r_lk_rvalid;
    assign lk_hit_o      = r_lk_hit;
    assign lk_attr_o     = r_lk_attr;

endmodule
`default_nettype wire
